// File: rtl/npc_unit_if.sv
// D-stage decision bundle between the pipeline control and the next-PC unit.
// The pipeline is the master; npc_unit is the slave that returns the fetch PC and status.
interface npc_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic [WIDTH-1:0] pc_d;
  logic [2:0]       cmp_op;
  logic [1:0]       jump_op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [15:0]      imm16;
  logic [25:0]      imm26;
  logic             err_clr;
  logic [WIDTH-1:0] pc_f;
  logic [2:0]       pc_sel;
  logic             taken;
  logic [CNT_W-1:0] cnt_taken;
  logic [CNT_W-1:0] cnt_stall;
  logic             align_err;
  logic [WIDTH-1:0] err_pc;

  modport master (
    output stall, pc_d, cmp_op, jump_op, rs_val, rt_val, imm16, imm26, err_clr,
    input  pc_f, pc_sel, taken, cnt_taken, cnt_stall, align_err, err_pc
  );

  modport slave (
    input  stall, pc_d, cmp_op, jump_op, rs_val, rt_val, imm16, imm26, err_clr,
    output pc_f, pc_sel, taken, cnt_taken, cnt_stall, align_err, err_pc
  );
endinterface

// File: rtl/npc_unit.sv
// Next-PC unit: owns the fetch PC, resolves D-stage branches/jumps with stall hold,
// and keeps saturating redirect/stall counters plus a sticky jr misalignment capture.
module npc_unit #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input logic       clk,
  input logic       reset,
  npc_unit_if.slave bus
);

  typedef enum logic [2:0] {
    SEL_SEQ = 3'b000,
    SEL_BR  = 3'b001,
    SEL_J   = 3'b010,
    SEL_JR  = 3'b011
  } pc_sel_e;

  localparam logic [2:0] CMP_BEQ  = 3'b001;
  localparam logic [2:0] CMP_BNE  = 3'b010;
  localparam logic [2:0] CMP_BLEZ = 3'b011;
  localparam logic [2:0] CMP_BGTZ = 3'b100;
  localparam logic [2:0] CMP_BLTZ = 3'b101;
  localparam logic [2:0] CMP_BGEZ = 3'b110;

  localparam logic [1:0] JMP_J  = 2'b01;
  localparam logic [1:0] JMP_JR = 2'b10;

  logic [WIDTH-1:0] pc_f_q, pc_f_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic             align_err_q, align_err_d;
  logic [WIDTH-1:0] err_pc_q, err_pc_d;

  logic [WIDTH-1:0] pc_plus4_d;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] jr_tgt;
  logic             rs_zero;
  logic             rs_neg;
  logic             cond;
  pc_sel_e          sel;
  logic             jr_misaligned;

  always_comb begin
    pc_plus4_d = bus.pc_d + WIDTH'(4);
    imm_sext   = {{(WIDTH-16){bus.imm16[15]}}, bus.imm16};
    br_tgt     = pc_plus4_d + (imm_sext << 2);
    j_tgt      = {pc_plus4_d[WIDTH-1:28], bus.imm26, 2'b00};
    jr_tgt     = {bus.rs_val[WIDTH-1:2], 2'b00};
    rs_zero    = (bus.rs_val == '0);
    rs_neg     = bus.rs_val[WIDTH-1];

    cond = 1'b0;
    unique case (bus.cmp_op)
      CMP_BEQ:  cond = (bus.rs_val == bus.rt_val);
      CMP_BNE:  cond = (bus.rs_val != bus.rt_val);
      CMP_BLEZ: cond = rs_neg | rs_zero;
      CMP_BGTZ: cond = ~rs_neg & ~rs_zero;
      CMP_BLTZ: cond = rs_neg;
      CMP_BGEZ: cond = ~rs_neg;
      default:  cond = 1'b0;
    endcase

    // Jumps outrank a branch decoded in the same slot.
    if (bus.jump_op == JMP_JR)     sel = SEL_JR;
    else if (bus.jump_op == JMP_J) sel = SEL_J;
    else if (cond)                 sel = SEL_BR;
    else                           sel = SEL_SEQ;
  end

  assign bus.pc_sel = sel;
  assign bus.taken  = (sel != SEL_SEQ);

  always_comb begin
    pc_f_d        = pc_f_q;
    cnt_taken_d   = cnt_taken_q;
    cnt_stall_d   = cnt_stall_q;
    align_err_d   = align_err_q;
    err_pc_d      = err_pc_q;
    jr_misaligned = (sel == SEL_JR) && (bus.rs_val[1:0] != 2'b00);

    if (bus.stall) begin
      cnt_stall_d = cnt_stall_q + CNT_W'(cnt_stall_q != '1);
    end else begin
      unique case (sel)
        SEL_BR:  pc_f_d = br_tgt;
        SEL_J:   pc_f_d = j_tgt;
        SEL_JR:  pc_f_d = jr_tgt;
        default: pc_f_d = pc_f_q + WIDTH'(4);
      endcase
      if (sel != SEL_SEQ) cnt_taken_d = cnt_taken_q + CNT_W'(cnt_taken_q != '1);

      // A fresh misalignment beats a clear; only the first raw target is kept.
      if (jr_misaligned) begin
        align_err_d = 1'b1;
        if (!align_err_q) err_pc_d = bus.rs_val;
      end else if (bus.err_clr) begin
        align_err_d = 1'b0;
        err_pc_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q      <= WIDTH'(RESET_PC);
      cnt_taken_q <= '0;
      cnt_stall_q <= '0;
      align_err_q <= 1'b0;
      err_pc_q    <= '0;
    end else begin
      pc_f_q      <= pc_f_d;
      cnt_taken_q <= cnt_taken_d;
      cnt_stall_q <= cnt_stall_d;
      align_err_q <= align_err_d;
      err_pc_q    <= err_pc_d;
    end
  end

  assign bus.pc_f      = pc_f_q;
  assign bus.cnt_taken = cnt_taken_q;
  assign bus.cnt_stall = cnt_stall_q;
  assign bus.align_err = align_err_q;
  assign bus.err_pc    = err_pc_q;

endmodule

// File: tb/tb_npc_unit.sv
// Self-checking bench for npc_unit: directed scenarios plus a randomized run
// against an arithmetic reference model of the next-PC rules.
module tb_npc_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  npc_unit_if #(.WIDTH(32), .CNT_W(16)) bus ();
  npc_unit_if #(.WIDTH(32), .CNT_W(2))  bus2 ();

  npc_unit #(.WIDTH(32), .RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  npc_unit #(.WIDTH(32), .RESET_PC(32'h0000_3000), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.pc_d = 0; bus.cmp_op = 0; bus.jump_op = 0;
    bus.rs_val = 0; bus.rt_val = 0; bus.imm16 = 0; bus.imm26 = 0; bus.err_clr = 0;
    bus2.stall = 0; bus2.pc_d = 0; bus2.cmp_op = 0; bus2.jump_op = 0;
    bus2.rs_val = 0; bus2.rt_val = 0; bus2.imm16 = 0; bus2.imm26 = 0; bus2.err_clr = 0;
  endtask

  task automatic do_reset(int cycles);
    idle_inputs();
    reset = 1;
    repeat (cycles) tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.stall = 1; bus.err_clr = 1; bus.jump_op = 2'b01;
    reset = 1;
    repeat (2) tick();
    reset = 0;
    n_cmp++; if (bus.pc_f !== 32'h3000) begin n_bad++; $display("[TB] FAIL reset_pc got=%h exp=%h", bus.pc_f, 32'h3000); end
    n_cmp++; if (bus.cnt_taken !== 16'd0 || bus.cnt_stall !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", bus.cnt_taken, bus.cnt_stall); end
    n_cmp++; if (bus.align_err !== 1'b0 || bus.err_pc !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_err got=%b/%h exp=0/0", bus.align_err, bus.err_pc); end
    idle_inputs();
    repeat (3) tick();
    n_cmp++; if (bus.pc_f !== 32'h300C) begin n_bad++; $display("[TB] FAIL idle_seq got=%h exp=%h", bus.pc_f, 32'h300C); end
  endtask

  task automatic test_branch();
    do_reset(1);
    bus.pc_d = 32'h3004; bus.cmp_op = 3'b001; bus.rs_val = 5; bus.rt_val = 5; bus.imm16 = 16'hFFFF;
    #1;
    n_cmp++; if (bus.pc_sel !== 3'b001 || bus.taken !== 1'b1) begin n_bad++; $display("[TB] FAIL beq_sel got=%b/%b exp=001/1", bus.pc_sel, bus.taken); end
    tick();
    n_cmp++; if (bus.pc_f !== 32'h3004) begin n_bad++; $display("[TB] FAIL beq_target got=%h exp=%h", bus.pc_f, 32'h3004); end
    bus.rt_val = 6;
    #1;
    n_cmp++; if (bus.pc_sel !== 3'b000 || bus.taken !== 1'b0) begin n_bad++; $display("[TB] FAIL beq_nt_sel got=%b/%b exp=000/0", bus.pc_sel, bus.taken); end
    tick();
    n_cmp++; if (bus.pc_f !== 32'h3008) begin n_bad++; $display("[TB] FAIL beq_nt_pc got=%h exp=%h", bus.pc_f, 32'h3008); end
    n_cmp++; if (bus.cnt_taken !== 16'd1) begin n_bad++; $display("[TB] FAIL beq_nt_cnt got=%0d exp=1", bus.cnt_taken); end
  endtask

  task automatic test_signed();
    logic [31:0] rs_tab [2];
    logic [2:0]  op_tab [4];
    logic        exp_tab [8];
    rs_tab = '{32'h8000_0000, 32'h0};
    op_tab = '{3'b101, 3'b110, 3'b011, 3'b100};
    exp_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    idle_inputs();
    for (int r = 0; r < 2; r++) begin
      for (int o = 0; o < 4; o++) begin
        bus.rs_val = rs_tab[r]; bus.cmp_op = op_tab[o];
        #1;
        n_cmp++;
        if (bus.taken !== exp_tab[r*4+o]) begin
          n_bad++; $display("[TB] FAIL signed_cmp op=%b rs=%h got=%b exp=%b", op_tab[o], rs_tab[r], bus.taken, exp_tab[r*4+o]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_stall_branch();
    do_reset(1);
    bus.pc_d = 32'h3000; bus.cmp_op = 3'b001; bus.rs_val = 9; bus.rt_val = 9; bus.imm16 = 16'h0004;
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.pc_f !== 32'h3000) begin n_bad++; $display("[TB] FAIL stall_hold cyc=%0d got=%h exp=%h", i, bus.pc_f, 32'h3000); end
    end
    n_cmp++; if (bus.cnt_stall !== 16'd3 || bus.cnt_taken !== 16'd0) begin n_bad++; $display("[TB] FAIL stall_cnt got=%0d/%0d exp=3/0", bus.cnt_stall, bus.cnt_taken); end
    bus.stall = 0;
    tick();
    n_cmp++; if (bus.pc_f !== 32'h3014) begin n_bad++; $display("[TB] FAIL stall_release got=%h exp=%h", bus.pc_f, 32'h3014); end
    n_cmp++; if (bus.cnt_taken !== 16'd1 || bus.cnt_stall !== 16'd3) begin n_bad++; $display("[TB] FAIL stall_release_cnt got=%0d/%0d exp=1/3", bus.cnt_taken, bus.cnt_stall); end
  endtask

  task automatic test_jr_align();
    do_reset(1);
    bus.jump_op = 2'b10; bus.rs_val = 32'h3013;
    #1;
    n_cmp++; if (bus.pc_sel !== 3'b011) begin n_bad++; $display("[TB] FAIL jr_sel got=%b exp=011", bus.pc_sel); end
    tick();
    n_cmp++; if (bus.pc_f !== 32'h3010) begin n_bad++; $display("[TB] FAIL jr_target got=%h exp=%h", bus.pc_f, 32'h3010); end
    n_cmp++; if (bus.align_err !== 1'b1 || bus.err_pc !== 32'h3013) begin n_bad++; $display("[TB] FAIL jr_err1 got=%b/%h exp=1/3013", bus.align_err, bus.err_pc); end
    bus.rs_val = 32'h3021; bus.cmp_op = 3'b001;
    tick();
    n_cmp++; if (bus.pc_f !== 32'h3020 || bus.err_pc !== 32'h3013) begin n_bad++; $display("[TB] FAIL jr_err2 got=%h/%h exp=3020/3013", bus.pc_f, bus.err_pc); end
    idle_inputs(); bus.err_clr = 1;
    tick();
    n_cmp++; if (bus.align_err !== 1'b0 || bus.err_pc !== 32'h0) begin n_bad++; $display("[TB] FAIL err_clr got=%b/%h exp=0/0", bus.align_err, bus.err_pc); end
    bus.jump_op = 2'b10; bus.rs_val = 32'h4002;
    tick();
    n_cmp++; if (bus.align_err !== 1'b1 || bus.err_pc !== 32'h4002) begin n_bad++; $display("[TB] FAIL set_over_clr got=%b/%h exp=1/4002", bus.align_err, bus.err_pc); end
    idle_inputs();
  endtask

  task automatic test_saturate();
    do_reset(1);
    bus2.jump_op = 2'b01; bus2.pc_d = 32'h3000; bus2.imm26 = 26'h0000C00;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++;
      if (bus2.cnt_taken !== 2'((i > 3) ? 3 : i)) begin
        n_bad++; $display("[TB] FAIL sat_cnt i=%0d got=%0d exp=%0d", i, bus2.cnt_taken, (i > 3) ? 3 : i);
      end
    end
    bus2.pc_d = 32'hF000_0000; bus2.imm26 = 26'h0000040;
    tick();
    n_cmp++; if (bus2.pc_f !== 32'hF000_0100) begin n_bad++; $display("[TB] FAIL j_region got=%h exp=%h", bus2.pc_f, 32'hF000_0100); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] e_pc, e_ep, tgt;
    logic [15:0] e_ct, e_cs;
    logic        e_ae, cnd;
    logic [2:0]  e_sel;
    int          rs_s;
    do_reset(1);
    e_pc = 32'h3000; e_ct = 0; e_cs = 0; e_ae = 0; e_ep = 0;
    for (int it = 0; it < 400; it++) begin
      bus.pc_d    = $urandom;
      bus.cmp_op  = 3'($urandom_range(0, 7));
      bus.jump_op = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      case ($urandom_range(0, 3))
        0: bus.rs_val = 32'h0;
        1: bus.rs_val = 32'h8000_0000;
        2: bus.rs_val = {$urandom_range(0, 1023), 2'($urandom_range(0, 3))};
        default: bus.rs_val = $urandom;
      endcase
      bus.rt_val  = ($urandom_range(0, 1) == 0) ? bus.rs_val : $urandom;
      bus.imm16   = 16'($urandom);
      bus.imm26   = 26'($urandom);
      bus.stall   = ($urandom_range(0, 3) == 0);
      bus.err_clr = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 40) == 0);

      rs_s = $signed(bus.rs_val);
      case (bus.cmp_op)
        3'd1: cnd = (bus.rs_val == bus.rt_val);
        3'd2: cnd = (bus.rs_val != bus.rt_val);
        3'd3: cnd = (rs_s <= 0);
        3'd4: cnd = (rs_s > 0);
        3'd5: cnd = (rs_s < 0);
        3'd6: cnd = (rs_s >= 0);
        default: cnd = 0;
      endcase
      if (bus.jump_op == 2'b10)      e_sel = 3'd3;
      else if (bus.jump_op == 2'b01) e_sel = 3'd2;
      else if (cnd)                  e_sel = 3'd1;
      else                           e_sel = 3'd0;
      #1;
      n_cmp++;
      if (bus.pc_sel !== e_sel || bus.taken !== (e_sel != 0)) begin
        n_bad++; $display("[TB] FAIL rnd_sel it=%0d got=%b/%b exp=%b/%b", it, bus.pc_sel, bus.taken, e_sel, e_sel != 0);
      end

      case (e_sel)
        3'd1: tgt = bus.pc_d + 32'd4 + 32'($signed(bus.imm16) * 4);
        3'd2: tgt = ((bus.pc_d + 32'd4) & 32'hF000_0000) | (32'(bus.imm26) * 4);
        3'd3: tgt = bus.rs_val & ~32'd3;
        default: tgt = e_pc + 32'd4;
      endcase
      if (reset) begin
        e_pc = 32'h3000; e_ct = 0; e_cs = 0; e_ae = 0; e_ep = 0;
      end else if (bus.stall) begin
        if (e_cs != 16'hFFFF) e_cs = e_cs + 1;
      end else begin
        e_pc = tgt;
        if (e_sel != 0 && e_ct != 16'hFFFF) e_ct = e_ct + 1;
        if (e_sel == 3 && bus.rs_val[1:0] != 0) begin
          if (!e_ae) e_ep = bus.rs_val;
          e_ae = 1;
        end else if (bus.err_clr) begin
          e_ae = 0; e_ep = 0;
        end
      end
      tick();
      reset = 0;
      n_cmp++;
      if (bus.pc_f !== e_pc || bus.cnt_taken !== e_ct || bus.cnt_stall !== e_cs ||
          bus.align_err !== e_ae || bus.err_pc !== e_ep) begin
        n_bad++;
        $display("[TB] FAIL rnd_state it=%0d got pc=%h ct=%0d cs=%0d ae=%b ep=%h exp pc=%h ct=%0d cs=%0d ae=%b ep=%h",
                 it, bus.pc_f, bus.cnt_taken, bus.cnt_stall, bus.align_err, bus.err_pc, e_pc, e_ct, e_cs, e_ae, e_ep);
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_branch();
    test_signed();
    test_stall_branch();
    test_jr_align();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
